// File: rtl/queue_transfer_pkg.sv
// Shared state encoding and default sizing for the deserializer-to-queue
// transfer controller.
package queue_transfer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENQ,
    WAIT,
    DROP,
    ACK
  } xfer_state_t;

  localparam int DATA_W_DEF      = 8;
  localparam int LEN_W_DEF       = 4;
  localparam int QUEUE_DEPTH_DEF = 8;
  localparam int TIMEOUT_DEF     = 15;
  localparam int DROP_W_DEF      = 8;

endpackage

// File: rtl/queue_transfer_ctrl_wait_timer.sv
// Counts cycles spent waiting for the queue to confirm an enqueue; expired
// is raised on the last allowed wait cycle.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int                 TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] LAST    = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Parks on LAST so a stale count can never wrap back below it.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && (count_q != LAST)) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/queue_transfer_ctrl.sv
// Moves each deserialized word into the queue with a four-phase
// data_ready_in / ack_out handshake, counting drops and flagging lost confirms.
module queue_transfer_ctrl
  import queue_transfer_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LEN_W       = LEN_W_DEF,
  parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int DROP_W      = DROP_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              data_ready_in,
  input  logic [DATA_W-1:0] des_data_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic              enqueue_out,
  output logic [DATA_W-1:0] queue_data_out,
  output logic              ack_out,
  output logic              busy_out,
  output logic [DROP_W-1:0] drop_count_out,
  output logic              error_out
);

  localparam logic [LEN_W-1:0]  FULL_LEN = LEN_W'(QUEUE_DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  xfer_state_t       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  snap_q, snap_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              error_q, error_d;
  logic              enq_q, enq_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;

  logic timer_clear;
  logic timer_run;
  logic timer_expired;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .run     (timer_run),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    snap_d      = snap_q;
    drop_d      = drop_q;
    error_d     = error_q;
    timer_clear = 1'b0;
    timer_run   = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_ready_in) begin
          data_d  = des_data_in;
          state_d = (len_in >= FULL_LEN) ? DROP : ENQ;
        end
      end
      ENQ: begin
        snap_d      = len_in;
        timer_clear = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        // A same-cycle dequeue can hide the enqueue; the timeout still acks the word.
        timer_run = 1'b1;
        if (len_in != snap_q) begin
          state_d = ACK;
        end else if (timer_expired) begin
          error_d = 1'b1;
          state_d = ACK;
        end
      end
      DROP: begin
        if (drop_q != DROP_MAX) begin
          drop_d = drop_q + DROP_W'(1);
        end
        state_d = ACK;
      end
      ACK: begin
        if (!data_ready_in) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    enq_d  = (state_d == ENQ);
    ack_d  = (state_d == ACK);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      snap_q  <= '0;
      drop_q  <= '0;
      error_q <= 1'b0;
      enq_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      snap_q  <= snap_d;
      drop_q  <= drop_d;
      error_q <= error_d;
      enq_q   <= enq_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign enqueue_out    = enq_q;
  assign queue_data_out = data_q;
  assign ack_out        = ack_q;
  assign busy_out       = busy_q;
  assign drop_count_out = drop_q;
  assign error_out      = error_q;

endmodule

// File: tb/tb_queue_transfer_ctrl.sv
// Scoreboard bench for queue_transfer_ctrl: stimulus queues expected enqueues
// and acks, a negedge monitor pops and compares them as the DUT presents them.
module tb_queue_transfer_ctrl;

  localparam int DATA_W      = 8;
  localparam int LEN_W       = 4;
  localparam int QUEUE_DEPTH = 8;
  localparam int TIMEOUT     = 15;
  localparam int DROP_W      = 8;

  typedef struct packed {
    logic              err;
    logic [DROP_W-1:0] drop;
  } ack_exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              data_ready_in = 1'b0;
  logic [DATA_W-1:0] des_data_in = '0;
  logic [LEN_W-1:0]  len_in = '0;
  logic              enqueue_out;
  logic [DATA_W-1:0] queue_data_out;
  logic              ack_out;
  logic              busy_out;
  logic [DROP_W-1:0] drop_count_out;
  logic              error_out;

  logic [DATA_W-1:0] exp_enq[$];
  ack_exp_t          exp_ack[$];

  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   enq_seen     = 0;
  int   drop_model   = 0;
  bit   err_model    = 1'b0;
  logic ack_prev     = 1'b0;

  queue_transfer_ctrl #(
    .DATA_W      (DATA_W),
    .LEN_W       (LEN_W),
    .QUEUE_DEPTH (QUEUE_DEPTH),
    .TIMEOUT     (TIMEOUT),
    .DROP_W      (DROP_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .data_ready_in  (data_ready_in),
    .des_data_in    (des_data_in),
    .len_in         (len_in),
    .enqueue_out    (enqueue_out),
    .queue_data_out (queue_data_out),
    .ack_out        (ack_out),
    .busy_out       (busy_out),
    .drop_count_out (drop_count_out),
    .error_out      (error_out)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic [DATA_W-1:0] data, input logic [LEN_W-1:0] len);
    data_ready_in = ready;
    des_data_in   = data;
    len_in        = len;
  endtask

  // One full handshake; bump_len=0 on a non-full queue exercises the timeout path.
  task automatic run_word(input logic [DATA_W-1:0] data, input logic [LEN_W-1:0] len0,
                          input bit bump_len, input int hold, input string tag);
    bit full;
    int lat;
    int exp_lat;
    int enq_before;
    full = (len0 >= LEN_W'(QUEUE_DEPTH));
    if (full) begin
      drop_model = (drop_model < 255) ? drop_model + 1 : 255;
      exp_lat    = 2;
    end else begin
      exp_enq.push_back(data);
      if (bump_len) begin
        exp_lat = 3;
      end else begin
        err_model = 1'b1;
        exp_lat   = TIMEOUT + 2;
      end
    end
    exp_ack.push_back('{err: err_model, drop: DROP_W'(drop_model)});
    applyStimulus(1'b1, data, len0);
    lat = 0;
    do begin
      tick(1);
      lat++;
      if (lat == 1) checkOutput({tag, "_busy"}, 32'(busy_out), 32'd1);
      if (!full && lat == 1) checkOutput({tag, "_enq_hi"}, 32'(enqueue_out), 32'd1);
      if (!full && lat == 2) begin
        checkOutput({tag, "_enq_lo"}, 32'(enqueue_out), 32'd0);
        if (bump_len) len_in = len0 + LEN_W'(1);
      end
    end while (!ack_out && lat < 200);
    checkOutput({tag, "_ack_lat"}, 32'(lat), 32'(exp_lat));
    enq_before = enq_seen;
    repeat (hold) tick(1);
    if (hold > 0) checkOutput({tag, "_ack_held"}, 32'(ack_out), 32'd1);
    data_ready_in = 1'b0;
    tick(1);
    checkOutput({tag, "_ack_rel"}, 32'(ack_out), 32'd0);
    checkOutput({tag, "_busy_idle"}, 32'(busy_out), 32'd0);
    checkOutput({tag, "_no_extra_enq"}, 32'(enq_seen), 32'(enq_before));
  endtask

  always @(negedge clock) begin
    ack_exp_t    a;
    logic [DATA_W-1:0] d;
    if (reset) begin
      ack_prev = 1'b0;
    end else begin
      if (enqueue_out) begin
        enq_seen++;
        if (exp_enq.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL enq_unexpected: got enqueue of %0h, expected none", queue_data_out);
        end else begin
          d = exp_enq.pop_front();
          checkOutput("enq_data", 32'(queue_data_out), 32'(d));
        end
      end
      if (ack_out && !ack_prev) begin
        if (exp_ack.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL ack_unexpected: got ack rise, expected none");
        end else begin
          a = exp_ack.pop_front();
          checkOutput("ack_error", 32'(error_out), 32'(a.err));
          checkOutput("ack_drops", 32'(drop_count_out), 32'(a.drop));
        end
      end
      ack_prev = ack_out;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, '0, '0);
    tick(2);
    checkOutput("rst_enq", 32'(enqueue_out), 32'd0);
    checkOutput("rst_ack", 32'(ack_out), 32'd0);
    checkOutput("rst_busy", 32'(busy_out), 32'd0);
    checkOutput("rst_drop", 32'(drop_count_out), 32'd0);
    checkOutput("rst_err", 32'(error_out), 32'd0);
    checkOutput("rst_data", 32'(queue_data_out), 32'd0);
    reset = 1'b0;
    tick(1);

    $display("[TB] normal transfer");
    run_word(8'hA5, 4'd2, 1'b1, 0, "t1");

    $display("[TB] queue full drops");
    run_word(8'h11, 4'd8, 1'b0, 0, "t2a");
    run_word(8'h22, 4'd8, 1'b0, 0, "t2b");
    run_word(8'h33, 4'd8, 1'b0, 0, "t2c");
    checkOutput("t2_drops", 32'(drop_count_out), 32'd3);

    $display("[TB] confirmation timeout");
    run_word(8'h3C, 4'd4, 1'b0, 0, "t3");
    checkOutput("t3_err", 32'(error_out), 32'd1);
    run_word(8'h77, 4'd4, 1'b1, 0, "t3g1");
    run_word(8'h88, 4'd5, 1'b1, 0, "t3g2");
    checkOutput("t3_err_sticky", 32'(error_out), 32'd1);

    $display("[TB] drop counter saturation");
    for (int i = 0; i < 260; i++) begin
      run_word(8'(i), LEN_W'(8 + (i % 8)), 1'b0, 0, "t4");
    end
    checkOutput("t4_drops_sat", 32'(drop_count_out), 32'hFF);

    $display("[TB] reset during wait");
    exp_enq.push_back(8'hC3);
    applyStimulus(1'b1, 8'hC3, 4'd5);
    tick(3);
    checkOutput("t5_busy_pre", 32'(busy_out), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t5_enq", 32'(enqueue_out), 32'd0);
    checkOutput("t5_ack", 32'(ack_out), 32'd0);
    checkOutput("t5_busy", 32'(busy_out), 32'd0);
    checkOutput("t5_drop", 32'(drop_count_out), 32'd0);
    checkOutput("t5_err", 32'(error_out), 32'd0);
    checkOutput("t5_data", 32'(queue_data_out), 32'd0);
    drop_model  = 0;
    err_model   = 1'b0;
    des_data_in = 8'h5A;
    tick(2);
    checkOutput("t5_busy_hold", 32'(busy_out), 32'd0);
    reset = 1'b0;
    run_word(8'h5A, 4'd5, 1'b1, 0, "t5b");

    $display("[TB] slow ack release");
    run_word(8'hE7, 4'd1, 1'b1, 10, "t6");

    tick(2);
    checkOutput("enq_queue_drained", 32'(exp_enq.size()), 32'd0);
    checkOutput("ack_queue_drained", 32'(exp_ack.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
